boreal_adc_frame_rx: RTL and testbench
======================================

# boreal_adc_frame_rx

SPI front-end for the 8-channel EEG ADC (ADS1299-class, 24-bit, status-word framed). It sits directly upstream of the cursor control pipeline. On each falling edge of the ADC's DRDY it clocks one full frame out of the device: a 24-bit status word followed by 8 × 24-bit channel words. It validates the status header, then replays the channel words as single-cycle `raw_adc_in`/`adc_channel_sel`/`adc_data_ready` strobes, the exact sample stream the cursor top consumes.

## Interface
Parameters:
- `SCLK_DIV`, 4: clk cycles per SCLK half-period; 100 MHz / 8 = 12.5 MHz SCLK; minimum 2.
- `CS_SETUP`, 2: clk cycles from `adc_cs_n` falling to the first SCLK rising edge.
- `CS_HOLD`, 2: clk cycles from the last SCLK falling edge to `adc_cs_n` rising.
- `EMIT_GAP`, 2: idle clk cycles between successive `adc_data_ready` pulses.

Ports:
- `clk`  in  1  system clock (100 MHz)
- `rst_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  arms capture; sampled only in IDLE
- `adc_drdy_n`  in  1  ADC data-ready (asynchronous, active low)
- `adc_miso`  in  1  ADC serial data
- `adc_sclk`  out  1  SPI clock (CPOL=0)
- `adc_cs_n`  out  1  SPI chip select
- `raw_adc_in`  out  24  channel word, two's complement, MSB first off the wire
- `adc_channel_sel`  out  3  channel index of `raw_adc_in`
- `adc_data_ready`  out  1  one-cycle word-valid strobe
- `status_word`  out  24  last *valid* status word
- `frame_err`  out  1  one-cycle pulse when a frame is dropped for a bad header
- `overrun`  out  1  one-cycle pulse when DRDY falls while busy
- `err_count`  out  8  saturating count of frame_err and overrun events combined
- `busy`  out  1  high outside IDLE

## Operation
- `adc_drdy_n` passes through a 2-FF synchronizer, then a registered falling-edge detect.
- FSM states: IDLE, SETUP, SHIFT, HOLD, CHECK, EMIT.
  - IDLE→SETUP on a DRDY fall with `enable`=1. `adc_cs_n` is driven low on entry.
  - SETUP lasts `CS_SETUP` cycles, then goes to SHIFT.
  - SHIFT runs 216 SCLK periods, i.e. 24 + 8×24 bits. SCLK idles low. On each period SCLK rises first. The cycle that drives SCLK low also samples `adc_miso` into a 24-bit shift register.
  - After every 24th bit: word 0 goes to the status register; words 1–8 go to an 8×24 buffer at index word−1.
  - A bit counter (0..215) ends SHIFT after the 216th falling edge.
  - HOLD lasts `CS_HOLD` cycles. `adc_cs_n` rises on exit to CHECK.
  - CHECK lasts 1 cycle:
    - if status[23:20]==4'hC, update `status_word` and go to EMIT;
    - otherwise pulse `frame_err`, increment `err_count`, go to IDLE.
  - EMIT: for ch 0..7, one cycle with `adc_data_ready`=1, `adc_channel_sel`=ch, `raw_adc_in`=buf[ch], followed by `EMIT_GAP` cycles with `adc_data_ready`=0. Return to IDLE after ch 7's gap.
- `raw_adc_in` and `adc_channel_sel` hold their last values between strobes.
- A DRDY fall in any state other than IDLE pulses `overrun` and increments `err_count`. The event is otherwise ignored and the current frame completes.
- A DRDY fall in IDLE with `enable`=0 is ignored silently.
- `enable` dropping mid-frame has no effect; the frame completes.
- `err_count` saturates at 255. A `frame_err` and an `overrun` in the same cycle add 2, still saturating.

## Timing
- Reset values: `adc_sclk`=0, `adc_cs_n`=1, `raw_adc_in`=0, `adc_channel_sel`=0, `adc_data_ready`=0, `status_word`=0, `frame_err`=0, `overrun`=0, `err_count`=0, `busy`=0, FSM=IDLE, synchronizer=all 1s.
- Reset asserted mid-frame: all outputs take their reset values immediately. `adc_cs_n` goes high asynchronously. The buffered frame is discarded.
- DRDY fall at the pin → `adc_cs_n` low 3 clk cycles later (2 sync + 1 edge).
- Bit period is 2×`SCLK_DIV` clk cycles.
- SHIFT lasts 216×2×`SCLK_DIV` cycles (1728 at defaults).
- First `adc_data_ready` comes 1 cycle after CHECK. Strobes are spaced `EMIT_GAP`+1 cycles apart (ch 7 at +21 at defaults).
- DRDY-fall-to-ch0-strobe at defaults: 3+2+1728+2+1+1 = 1737 cycles. This fits within the 4 ms frame period at 250 SPS.
- `adc_miso` is sampled unsynchronized; its timing is covered by SDC constraints relative to `adc_sclk`.

## Structure
- Package `boreal_adc_pkg` holds:
  - the FSM state enum;
  - `STATUS_SYNC` = 4'hC;
  - `N_CH` = 8;
  - `WORD_BITS` = 24;
  - `FRAME_BITS` = 216.
- Sub-module `boreal_sclk_gen` produces `adc_sclk` plus one-cycle `sclk_rise`/`sclk_fall` strobes. Its ports are `run` and `SCLK_DIV`. It restarts with SCLK low whenever `run` deasserts.

## Test plan
- **Nominal frame:** ADC model sends status 0xC00000 and channels ch_k = 0x100000 + k. Required: 8 strobes, ch 0..7 in order, 3 cycles apart, with matching data; `status_word`=0xC00000; `err_count`=0.
- **Bad header:** status 0x800000. Required: `frame_err` pulses once in CHECK; no `adc_data_ready`; `status_word` unchanged; `err_count`=1.
- **Overrun:** a second DRDY fall during SHIFT. Required: one `overrun` pulse; the first frame is emitted intact; `err_count`=1; no second capture.
- **Reset mid-frame:** `rst_n` pulsed low at bit 100. Required: `adc_cs_n`=1 and `adc_sclk`=0 while in reset; no strobes; the next DRDY yields a clean frame.
- **SCLK/CS timing:** at `SCLK_DIV`=4, measure 8-cycle SCLK periods and exactly 216 rising edges. Required: `adc_cs_n` low 2 cycles before the first rise and high 2 cycles after the last fall.
- **Enable gating and saturation:**
  - `enable`=0 at the DRDY fall → no capture, no error.
  - 300 consecutive bad headers → `err_count` holds at 255.

Source files
------------

// File: rtl/boreal_adc_pkg.sv
// Shared types and constants for the Boreal ADC frame receiver.
package boreal_adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_CHECK,
        ST_EMIT
    } state_t;

    localparam logic [3:0]  STATUS_SYNC = 4'hC;
    localparam int unsigned N_CH        = 8;
    localparam int unsigned WORD_BITS   = 24;
    localparam int unsigned FRAME_BITS  = 216;

    // Error counter add of up to two events, clamped at 255.
    function automatic logic [7:0] sat_add_err(input logic [7:0] cnt, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {7'b0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/boreal_sclk_gen.sv
// SPI clock generator (CPOL=0): SCLK rises at the start of each period; strobes mark
// the cycle whose clock edge drives SCLK high (sclk_rise) or low (sclk_fall).
module boreal_sclk_gen #(
    parameter int unsigned SCLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic sclk,
    output logic sclk_rise,
    output logic sclk_fall
);

    localparam int unsigned PERIOD = 2 * SCLK_DIV;
    localparam int unsigned CW     = $clog2(PERIOD);

    logic [CW-1:0] cnt;

    assign sclk_rise = run && (cnt == '0);
    assign sclk_fall = run && (cnt == CW'(SCLK_DIV));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (!run) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else begin
            sclk <= (cnt < CW'(SCLK_DIV));
            cnt  <= (cnt == CW'(PERIOD - 1)) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/boreal_adc_frame_rx.sv
// DRDY-triggered SPI capture of one status + 8-channel ADC frame, header validation,
// then replay of the channel words as single-cycle sample strobes.
module boreal_adc_frame_rx
    import boreal_adc_pkg::*;
#(
    parameter int unsigned SCLK_DIV = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned EMIT_GAP = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 adc_drdy_n,
    input  logic                 adc_miso,
    output logic                 adc_sclk,
    output logic                 adc_cs_n,
    output logic [WORD_BITS-1:0] raw_adc_in,
    output logic [2:0]           adc_channel_sel,
    output logic                 adc_data_ready,
    output logic [WORD_BITS-1:0] status_word,
    output logic                 frame_err,
    output logic                 overrun,
    output logic [7:0]           err_count,
    output logic                 busy
);

    state_t               state;
    logic                 drdy_s1, drdy_s2, drdy_s3;
    logic                 drdy_fall;
    logic                 run, sclk_rise, sclk_fall;
    logic [7:0]           tmr;
    logic [7:0]           bit_cnt;
    logic [4:0]           bit_in_word;
    logic [3:0]           word_idx;
    logic [2:0]           buf_idx;
    logic [2:0]           next_ch;
    logic [WORD_BITS-1:0] shreg, word_next, status_shadow;
    logic [WORD_BITS-1:0] chan_buf [N_CH];
    logic                 header_ok;
    logic                 bad_hdr_evt, overrun_evt;
    logic [1:0]           err_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drdy_s1 <= 1'b1;
            drdy_s2 <= 1'b1;
            drdy_s3 <= 1'b1;
        end else begin
            drdy_s1 <= adc_drdy_n;
            drdy_s2 <= drdy_s1;
            drdy_s3 <= drdy_s2;
        end
    end

    assign drdy_fall = drdy_s3 & ~drdy_s2;

    // SCLK starts in the last SETUP cycle so its first rise lands exactly CS_SETUP after CS.
    assign run = (state == ST_SHIFT) || (state == ST_SETUP && tmr == 8'(CS_SETUP - 1));

    boreal_sclk_gen #(
        .SCLK_DIV(SCLK_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .sclk      (adc_sclk),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall)
    );

    assign word_next   = {shreg[WORD_BITS-2:0], adc_miso};
    assign buf_idx     = word_idx[2:0] - 3'd1;
    assign next_ch     = adc_channel_sel + 3'd1;
    assign header_ok   = (status_shadow[23:20] == STATUS_SYNC);
    assign bad_hdr_evt = (state == ST_CHECK) && !header_ok;
    assign overrun_evt = drdy_fall && (state != ST_IDLE);
    assign err_inc     = {1'b0, bad_hdr_evt} + {1'b0, overrun_evt};
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            adc_cs_n        <= 1'b1;
            raw_adc_in      <= '0;
            adc_channel_sel <= '0;
            adc_data_ready  <= 1'b0;
            status_word     <= '0;
            frame_err       <= 1'b0;
            overrun         <= 1'b0;
            err_count       <= '0;
            tmr             <= '0;
            bit_cnt         <= '0;
            bit_in_word     <= '0;
            word_idx        <= '0;
            shreg           <= '0;
            status_shadow   <= '0;
            for (int unsigned i = 0; i < N_CH; i++) chan_buf[i] <= '0;
        end else begin
            frame_err      <= bad_hdr_evt;
            overrun        <= overrun_evt;
            adc_data_ready <= 1'b0;
            err_count      <= sat_add_err(err_count, err_inc);

            case (state)
                ST_IDLE: begin
                    if (drdy_fall && enable) begin
                        state       <= ST_SETUP;
                        adc_cs_n    <= 1'b0;
                        tmr         <= '0;
                        bit_cnt     <= '0;
                        bit_in_word <= '0;
                        word_idx    <= '0;
                    end
                end

                ST_SETUP: begin
                    if (sclk_rise) state <= ST_SHIFT;
                    else           tmr   <= tmr + 8'd1;
                end

                ST_SHIFT: begin
                    if (sclk_fall) begin
                        shreg   <= word_next;
                        bit_cnt <= bit_cnt + 8'd1;
                        if (bit_in_word == 5'(WORD_BITS - 1)) begin
                            bit_in_word <= '0;
                            word_idx    <= word_idx + 4'd1;
                            if (word_idx == '0) status_shadow     <= word_next;
                            else                chan_buf[buf_idx] <= word_next;
                        end else begin
                            bit_in_word <= bit_in_word + 5'd1;
                        end
                        // Leave on the final falling edge so HOLD is timed from the last SCLK fall.
                        if (bit_cnt == 8'(FRAME_BITS - 1)) begin
                            state <= ST_HOLD;
                            tmr   <= '0;
                        end
                    end
                end

                ST_HOLD: begin
                    if (tmr == 8'(CS_HOLD - 1)) begin
                        adc_cs_n <= 1'b1;
                        state    <= ST_CHECK;
                    end else begin
                        tmr <= tmr + 8'd1;
                    end
                end

                ST_CHECK: begin
                    if (header_ok) begin
                        status_word     <= status_shadow;
                        adc_data_ready  <= 1'b1;
                        adc_channel_sel <= '0;
                        raw_adc_in      <= chan_buf[0];
                        tmr             <= '0;
                        state           <= ST_EMIT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_EMIT: begin
                    if (tmr == 8'(EMIT_GAP)) begin
                        if (adc_channel_sel == 3'(N_CH - 1)) begin
                            state <= ST_IDLE;
                        end else begin
                            adc_data_ready  <= 1'b1;
                            adc_channel_sel <= next_ch;
                            raw_adc_in      <= chan_buf[next_ch];
                            tmr             <= '0;
                        end
                    end else begin
                        tmr <= tmr + 8'd1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_boreal_adc_frame_rx.sv
// Randomized bench for boreal_adc_frame_rx: an ADC serial model feeds frames and a
// queue-based reference predicts strobes, status, error pulses and SPI timing.
`timescale 1ns/1ps
module tb_boreal_adc_frame_rx;

    localparam int unsigned SCLK_DIV = 4;
    localparam int unsigned CS_SETUP = 2;
    localparam int unsigned CS_HOLD  = 2;
    localparam int unsigned EMIT_GAP = 2;

    logic        clk = 1'b0;
    logic        rst_n, enable, adc_drdy_n, adc_miso;
    logic        adc_sclk, adc_cs_n, adc_data_ready, frame_err, overrun, busy;
    logic [23:0] raw_adc_in, status_word;
    logic [2:0]  adc_channel_sel;
    logic [7:0]  err_count;

    boreal_adc_frame_rx #(
        .SCLK_DIV(SCLK_DIV),
        .CS_SETUP(CS_SETUP),
        .CS_HOLD (CS_HOLD),
        .EMIT_GAP(EMIT_GAP)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .adc_drdy_n      (adc_drdy_n),
        .adc_miso        (adc_miso),
        .adc_sclk        (adc_sclk),
        .adc_cs_n        (adc_cs_n),
        .raw_adc_in      (raw_adc_in),
        .adc_channel_sel (adc_channel_sel),
        .adc_data_ready  (adc_data_ready),
        .status_word     (status_word),
        .frame_err       (frame_err),
        .overrun         (overrun),
        .err_count       (err_count),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int sat_add(input int a, input int b);
        return (a + b > 255) ? 255 : a + b;
    endfunction

    // ADC model: presents the next frame bit after each SCLK rise, MSB first.
    logic [215:0] tx_frame = '0;
    int           tx_idx   = 0;
    always @(negedge adc_cs_n) tx_idx = 0;
    always @(posedge adc_sclk) begin
        if (!adc_cs_n && tx_idx < 216) begin
            adc_miso = tx_frame[215 - tx_idx];
            tx_idx++;
        end
    end

    // Reference state
    int          exp_ch[$];
    logic [23:0] exp_dat[$];
    logic [23:0] exp_status = '0;
    logic [23:0] exp_raw    = '0;
    int          exp_sel    = 0;
    int          exp_err    = 0;
    int          exp_ferr   = 0;
    int          exp_ovr    = 0;
    logic [23:0] chv [8];

    // Observation state
    int          cyc = 0;
    int          obs_ferr = 0, obs_ovr = 0, cs_falls = 0;
    int          t_cs = 0, t_rise = 0, t_fall = 0, t_strobe = 0;
    int          rises_cnt = 0, bad_periods = 0, setup_gap = 0;
    bit          tim_armed = 1'b0;
    logic        prev_cs = 1'b1, prev_sclk = 1'b0;
    int          ec;
    logic [23:0] ed;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            tim_armed = 1'b0;
        end else begin
            if (prev_cs && !adc_cs_n) begin
                cs_falls++;
                t_cs        = cyc;
                rises_cnt   = 0;
                bad_periods = 0;
                tim_armed   = 1'b1;
            end
            if (!prev_sclk && adc_sclk) begin
                if (rises_cnt == 0) setup_gap = cyc - t_cs;
                else if (cyc - t_rise != 2 * SCLK_DIV) bad_periods++;
                t_rise = cyc;
                rises_cnt++;
            end
            if (prev_sclk && !adc_sclk) t_fall = cyc;
            if (!prev_cs && adc_cs_n && tim_armed) begin
                check_eq("sclk_rises", rises_cnt, 216);
                check_eq("cs_setup", setup_gap, CS_SETUP);
                check_eq("cs_hold", cyc - t_fall, CS_HOLD);
                check_eq("sclk_period_errs", bad_periods, 0);
                tim_armed = 1'b0;
            end
            if (frame_err) obs_ferr++;
            if (overrun)   obs_ovr++;
            if (adc_data_ready) begin
                check_eq("strobe_expected", exp_ch.size() != 0, 1);
                if (exp_ch.size() != 0) begin
                    ec = exp_ch.pop_front();
                    ed = exp_dat.pop_front();
                    check_eq("strobe_sel", adc_channel_sel, ec);
                    check_eq("strobe_data", raw_adc_in, ed);
                    if (ec != 0) check_eq("strobe_gap", cyc - t_strobe, EMIT_GAP + 1);
                    t_strobe = cyc;
                end
            end
        end
        prev_cs   = adc_cs_n;
        prev_sclk = adc_sclk;
    end

    task automatic pulse_drdy();
        adc_drdy_n = 1'b0;
        repeat (3) @(negedge clk);
        adc_drdy_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic rand_chans();
        for (int k = 0; k < 8; k++) chv[k] = 24'($urandom());
    endtask

    task automatic start_frame(input logic [23:0] st);
        tx_frame[215 -: 24] = st;
        for (int k = 0; k < 8; k++) tx_frame[191 - 24 * k -: 24] = chv[k];
        if (st[23:20] == 4'hC) begin
            for (int k = 0; k < 8; k++) begin
                exp_ch.push_back(k);
                exp_dat.push_back(chv[k]);
            end
            exp_status = st;
            exp_sel    = 7;
            exp_raw    = chv[7];
        end else begin
            exp_ferr++;
            exp_err = sat_add(exp_err, 1);
        end
        pulse_drdy();
    endtask

    task automatic finish_frame();
        int guard = 0;
        while (busy && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        check_eq("frame_done", busy, 0);
        repeat (2) @(negedge clk);
        check_eq("strobes_pending", exp_ch.size(), 0);
        check_eq("status_word", status_word, exp_status);
        check_eq("err_count", err_count, exp_err);
        check_eq("frame_err_pulses", obs_ferr, exp_ferr);
        check_eq("overrun_pulses", obs_ovr, exp_ovr);
        check_eq("hold_sel", adc_channel_sel, exp_sel);
        check_eq("hold_raw", raw_adc_in, exp_raw);
    endtask

    task automatic wait_rises(input int n);
        int guard = 0;
        while (rises_cnt < n && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check_eq("rises_reached", rises_cnt >= n, 1);
    endtask

    initial begin
        logic [23:0] st;
        int          n0;
        int          guard;

        rst_n      = 1'b0;
        enable     = 1'b1;
        adc_drdy_n = 1'b1;
        adc_miso   = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_sclk", adc_sclk, 0);
        check_eq("rst_cs_n", adc_cs_n, 1);
        check_eq("rst_raw", raw_adc_in, 0);
        check_eq("rst_sel", adc_channel_sel, 0);
        check_eq("rst_ready", adc_data_ready, 0);
        check_eq("rst_status", status_word, 0);
        check_eq("rst_frame_err", frame_err, 0);
        check_eq("rst_overrun", overrun, 0);
        check_eq("rst_err_count", err_count, 0);
        check_eq("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Nominal frame
        for (int k = 0; k < 8; k++) chv[k] = 24'h100000 + 24'(k);
        start_frame(24'hC00000);
        finish_frame();

        // Bad header
        rand_chans();
        start_frame(24'h800000);
        finish_frame();

        // Randomized frames, mostly valid headers
        for (int i = 0; i < 6; i++) begin
            rand_chans();
            st = 24'($urandom());
            if ($urandom_range(0, 2) != 0) st[23:20] = 4'hC;
            else if (st[23:20] == 4'hC) st[23:20] = 4'h8;
            start_frame(st);
            finish_frame();
        end

        // Overrun during SHIFT: one pulse, frame intact, no second capture
        n0 = cs_falls;
        rand_chans();
        start_frame({4'hC, 20'($urandom())});
        repeat (200) @(negedge clk);
        exp_ovr++;
        exp_err = sat_add(exp_err, 1);
        pulse_drdy();
        finish_frame();
        repeat (10) @(negedge clk);
        check_eq("overrun_one_capture", cs_falls - n0, 1);

        // Enable low: DRDY ignored silently
        enable = 1'b0;
        n0 = cs_falls;
        pulse_drdy();
        repeat (20) @(negedge clk);
        check_eq("disabled_busy", busy, 0);
        check_eq("disabled_capture", cs_falls - n0, 0);
        check_eq("disabled_err", err_count, exp_err);
        enable = 1'b1;

        // Bad header with DRDY falling during CHECK: both events count together
        rand_chans();
        start_frame(24'h3ABCDE);
        wait_rises(216);
        guard = 0;
        while (adc_sclk && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        adc_drdy_n = 1'b0;
        exp_ovr++;
        exp_err = sat_add(exp_err, 1);
        repeat (3) @(negedge clk);
        adc_drdy_n = 1'b1;
        finish_frame();

        // Reset mid-frame
        rand_chans();
        start_frame({4'hC, 20'($urandom())});
        wait_rises(100);
        rst_n = 1'b0;
        exp_ch.delete();
        exp_dat.delete();
        exp_status = '0;
        exp_raw    = '0;
        exp_sel    = 0;
        exp_err    = 0;
        @(negedge clk);
        check_eq("midrst_cs_n", adc_cs_n, 1);
        check_eq("midrst_sclk", adc_sclk, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_err", err_count, 0);
        repeat (4) @(negedge clk);
        check_eq("midrst_sclk_held", adc_sclk, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        rand_chans();
        start_frame({4'hC, 20'($urandom())});
        finish_frame();

        // DRDY storms during SHIFT drive err_count into saturation
        for (int f = 0; f < 2; f++) begin
            rand_chans();
            start_frame({4'hC, 20'($urandom())});
            repeat (50) @(negedge clk);
            for (int p = 0; p < 200; p++) pulse_drdy();
            exp_ovr += 200;
            exp_err = sat_add(exp_err, 200);
            finish_frame();
        end
        for (int i = 0; i < 3; i++) begin
            rand_chans();
            start_frame({4'h1, 20'($urandom())});
            finish_frame();
        end
        check_eq("err_saturated", err_count, 255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
